// File: rtl/core_io_pkg.sv
// Shared definitions for the core I/O buffer: status register layout and
// serializer state encoding.
package core_io_pkg;

  localparam int TX_CNT_LSB  = 0;
  localparam int RX_CNT_LSB  = 16;
  localparam int CNT_FIELD_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/core_io_buffer_sync_fifo.sv
// First-word fall-through synchronous FIFO with registered occupancy count.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head reads as zero when empty so the storage array needs no reset.
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/core_io_buffer.sv
// Buffers core I/O words to and from a narrow byte-stream device, packing
// device beats little-endian into core words in both directions.
module core_io_buffer
  import core_io_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEV_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             out_issued,
  input  logic [XLEN-1:0]  out_data,
  output logic             out_stall,
  input  logic             in_issued,
  output logic [XLEN-1:0]  in_data,
  output logic             in_stall,
  output logic [31:0]      status,
  output logic             tx_valid,
  output logic [DEV_W-1:0] tx_data,
  input  logic             tx_ready,
  input  logic             rx_valid,
  input  logic [DEV_W-1:0] rx_data,
  output logic             rx_ready
);

  localparam int R  = XLEN / DEV_W;
  localparam int BW = (R > 1) ? $clog2(R) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(R - 1);

  // ---------------- TX path ----------------
  logic            tx_pop;
  logic            tx_full;
  logic            tx_empty;
  logic [XLEN-1:0] tx_head;
  logic [CW-1:0]   tx_cnt;

  sync_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (out_issued),
    .wdata (out_data),
    .pop   (tx_pop),
    .rdata (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_cnt)
  );

  ser_state_e      state;
  logic [XLEN-1:0] shift_q;
  logic [BW-1:0]   tx_beat;
  logic            tx_valid_q;
  logic            tx_last;

  assign tx_last  = (state == SEND) && tx_ready && (tx_beat == LAST_BEAT);
  // Reload on the last accepted beat keeps back-to-back words bubble-free.
  assign tx_pop   = !tx_empty && ((state == IDLE) || tx_last);
  assign tx_valid = tx_valid_q;
  assign tx_data  = shift_q[DEV_W-1:0];
  assign out_stall = tx_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift_q    <= '0;
      tx_beat    <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!tx_empty) begin
            state      <= SEND;
            tx_valid_q <= 1'b1;
            shift_q    <= tx_head;
            tx_beat    <= '0;
          end
        end
        SEND: begin
          if (tx_ready) begin
            if (tx_beat == LAST_BEAT) begin
              tx_beat <= '0;
              if (!tx_empty) begin
                shift_q <= tx_head;
              end else begin
                state      <= IDLE;
                tx_valid_q <= 1'b0;
                shift_q    <= '0;
              end
            end else begin
              shift_q <= shift_q >> DEV_W;
              tx_beat <= tx_beat + 1'b1;
            end
          end
        end
        default: begin
          state      <= IDLE;
          tx_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- RX path ----------------
  logic            rx_full;
  logic            rx_empty;
  logic [XLEN-1:0] rx_head;
  logic [CW-1:0]   rx_cnt;
  logic [XLEN-1:0] asm_q;
  logic [XLEN-1:0] rx_word;
  logic [BW-1:0]   rx_beat;
  logic            rx_accept;
  logic            rx_push;

  assign rx_ready  = !rx_full;
  assign rx_accept = rx_valid && rx_ready;
  assign rx_push   = rx_accept && (rx_beat == LAST_BEAT);

  // Completed word includes the beat arriving this cycle.
  always_comb begin
    rx_word = asm_q;
    rx_word[rx_beat*DEV_W +: DEV_W] = rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      asm_q   <= '0;
      rx_beat <= '0;
    end else if (rx_accept) begin
      if (rx_beat == LAST_BEAT) begin
        asm_q   <= '0;
        rx_beat <= '0;
      end else begin
        asm_q   <= rx_word;
        rx_beat <= rx_beat + 1'b1;
      end
    end
  end

  sync_fifo #(.W(XLEN), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .wdata (rx_word),
    .pop   (in_issued),
    .rdata (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_cnt)
  );

  assign in_data  = rx_head;
  assign in_stall = rx_empty;

  always_comb begin
    status = '0;
    status[TX_CNT_LSB +: CNT_FIELD_W] = CNT_FIELD_W'(tx_cnt);
    status[RX_CNT_LSB +: CNT_FIELD_W] = CNT_FIELD_W'(rx_cnt);
  end

endmodule

// File: tb/tb_core_io_buffer.sv
// Directed bench for core_io_buffer: a vector table for single-word TX/RX
// plus hand-written sequences for back-pressure, RX full and mid-transfer reset.
module tb_core_io_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        out_issued;
  logic [31:0] out_data;
  logic        out_stall;
  logic        in_issued;
  logic [31:0] in_data;
  logic        in_stall;
  logic [31:0] status;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  exp_q[$];
  logic [31:0] exp_wq[$];

  core_io_buffer #(.XLEN(32), .DEV_W(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .out_issued (out_issued),
    .out_data   (out_data),
    .out_stall  (out_stall),
    .in_issued  (in_issued),
    .in_data    (in_data),
    .in_stall   (in_stall),
    .status     (status),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver / checker ----------------
  typedef struct {
    logic        rst;
    logic        oi;
    logic [31:0] od;
    logic        ii;
    logic        tr;
    logic        rv;
    logic [7:0]  rd;
    logic        e_os;
    logic        e_is;
    logic [31:0] e_id;
    logic [31:0] e_st;
    logic        e_tv;
    logic [7:0]  e_td;
    logic        e_rr;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic oi, input logic [31:0] od,
                              input logic ii, input logic tr, input logic rv,
                              input logic [7:0] rd, input logic e_os, input logic e_is,
                              input logic [31:0] e_id, input logic [31:0] e_st,
                              input logic e_tv, input logic [7:0] e_td, input logic e_rr);
    vec_t v;
    v.rst = r;  v.oi = oi; v.od = od; v.ii = ii; v.tr = tr; v.rv = rv; v.rd = rd;
    v.e_os = e_os; v.e_is = e_is; v.e_id = e_id; v.e_st = e_st;
    v.e_tv = e_tv; v.e_td = e_td; v.e_rr = e_rr;
    return v;
  endfunction

  // Waits for the falling edge, then drives inputs for the coming rising edge.
  task automatic drive(input logic r, input logic oi, input logic [31:0] od,
                       input logic ii, input logic tr, input logic rv,
                       input logic [7:0] rd);
    @(negedge clk);
    rst = r; out_issued = oi; out_data = od; in_issued = ii;
    tx_ready = tr; rx_valid = rv; rx_data = rd;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " out_stall"}, 32'(out_stall), 32'd0);
    chk({tag, " in_stall"},  32'(in_stall),  32'd1);
    chk({tag, " in_data"},   in_data,        32'd0);
    chk({tag, " status"},    status,         32'd0);
    chk({tag, " tx_valid"},  32'(tx_valid),  32'd0);
    chk({tag, " tx_data"},   32'(tx_data),   32'd0);
    chk({tag, " rx_ready"},  32'(rx_ready),  32'd1);
  endtask

  function automatic logic [31:0] tx_word(input int i);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[b*8 +: 8] = 8'(8'h40 + i*16 + b);
    return w;
  endfunction

  // ---------------- test ----------------
  localparam logic [31:0] WA = 32'h44332211;
  localparam logic [31:0] WB = 32'hDEADBEEF;

  vec_t vt[19];
  logic pending;
  logic exp_stall;
  logic [7:0] beat;
  string tag;

  initial begin
    vt[0]  = mk(0,0,0, 0,0,0,8'h00,  0,1,0,0,          0,8'h00,1);
    vt[1]  = mk(0,1,WA,0,1,0,8'h00,  0,1,0,0,          0,8'h00,1);
    vt[2]  = mk(0,0,0, 0,1,0,8'h00,  0,1,0,32'h1,      0,8'h00,1);
    vt[3]  = mk(0,0,0, 0,1,0,8'h00,  0,1,0,0,          1,8'h11,1);
    vt[4]  = mk(0,0,0, 0,1,0,8'h00,  0,1,0,0,          1,8'h22,1);
    vt[5]  = mk(0,0,0, 0,1,0,8'h00,  0,1,0,0,          1,8'h33,1);
    vt[6]  = mk(0,0,0, 0,1,0,8'h00,  0,1,0,0,          1,8'h44,1);
    vt[7]  = mk(0,0,0, 0,1,0,8'h00,  0,1,0,0,          0,8'h00,1);
    vt[8]  = mk(0,0,0, 0,0,1,8'hEF,  0,1,0,0,          0,8'h00,1);
    vt[9]  = mk(0,0,0, 0,0,0,8'h00,  0,1,0,0,          0,8'h00,1);
    vt[10] = mk(0,0,0, 0,0,1,8'hBE,  0,1,0,0,          0,8'h00,1);
    vt[11] = mk(0,0,0, 0,0,0,8'h00,  0,1,0,0,          0,8'h00,1);
    vt[12] = mk(0,0,0, 0,0,1,8'hAD,  0,1,0,0,          0,8'h00,1);
    vt[13] = mk(0,0,0, 0,0,1,8'hDE,  0,1,0,0,          0,8'h00,1);
    vt[14] = mk(0,0,0, 0,0,0,8'h00,  0,0,WB,32'h10000, 0,8'h00,1);
    vt[15] = mk(0,0,0, 1,0,0,8'h00,  0,0,WB,32'h10000, 0,8'h00,1);
    vt[16] = mk(0,0,0, 0,0,0,8'h00,  0,1,0,0,          0,8'h00,1);
    vt[17] = mk(0,0,0, 1,0,0,8'h00,  0,1,0,0,          0,8'h00,1);
    vt[18] = mk(0,0,0, 0,0,0,8'h00,  0,1,0,0,          0,8'h00,1);

    drive(1, 0, 0, 0, 0, 0, 8'h00);
    drive(1, 0, 0, 0, 0, 0, 8'h00);

    // Table: reset state, single-word TX, gapped RX assembly, pop, pop-while-empty.
    for (int i = 0; i < 19; i++) begin
      drive(vt[i].rst, vt[i].oi, vt[i].od, vt[i].ii, vt[i].tr, vt[i].rv, vt[i].rd);
      tag = $sformatf("v%0d", i);
      chk({tag, " out_stall"}, 32'(out_stall), 32'(vt[i].e_os));
      chk({tag, " in_stall"},  32'(in_stall),  32'(vt[i].e_is));
      chk({tag, " in_data"},   in_data,        vt[i].e_id);
      chk({tag, " status"},    status,         vt[i].e_st);
      chk({tag, " tx_valid"},  32'(tx_valid),  32'(vt[i].e_tv));
      chk({tag, " tx_data"},   32'(tx_data),   32'(vt[i].e_td));
      chk({tag, " rx_ready"},  32'(rx_ready),  32'(vt[i].e_rr));
    end

    // TX back-pressure: six words pushed with tx_ready low; one sits in the
    // serializer, four fill the FIFO, the sixth stalls.
    for (int i = 0; i < 6; i++)
      for (int b = 0; b < 4; b++) exp_q.push_back(8'(8'h40 + i*16 + b));
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, tx_word(i), 0, 0, 0, 8'h00);
      chk($sformatf("bp push%0d out_stall", i), 32'(out_stall), 32'd0);
      chk($sformatf("bp push%0d tx_cnt", i), status,
          (i == 0) ? 32'd0 : (i <= 2) ? 32'd1 : 32'(i - 1));
      if (i >= 2) begin
        chk($sformatf("bp hold%0d tx_valid", i), 32'(tx_valid), 32'd1);
        chk($sformatf("bp hold%0d tx_data", i), 32'(tx_data), 32'h40);
      end
    end
    drive(0, 1, tx_word(5), 0, 0, 0, 8'h00);
    chk("bp full out_stall", 32'(out_stall), 32'd1);
    chk("bp full tx_cnt", status, 32'd4);
    chk("bp full tx_data", 32'(tx_data), 32'h40);

    pending = 1'b1;
    for (int k = 0; k < 24; k++) begin
      drive(0, pending, tx_word(5), 0, 1, 0, 8'h00);
      beat = exp_q.pop_front();
      exp_stall = (k < 4) || (k >= 5 && k < 8);
      chk($sformatf("stream k%0d tx_valid", k), 32'(tx_valid), 32'd1);
      chk($sformatf("stream k%0d tx_data", k), 32'(tx_data), 32'(beat));
      chk($sformatf("stream k%0d out_stall", k), 32'(out_stall), 32'(exp_stall));
      if (pending && !out_stall) pending = 1'b0;
    end
    drive(0, 0, 0, 0, 1, 0, 8'h00);
    chk("stream end tx_valid", 32'(tx_valid), 32'd0);
    chk("stream end status", status, 32'd0);
    chk("stream end word5 accepted", 32'(pending), 32'd0);

    // RX full: four words fill the FIFO, extra beats are refused until a pop.
    for (int i = 0; i < 4; i++) begin
      exp_wq.push_back({8'(8'hC0 + i), 8'(8'hB0 + i), 8'(8'hA0 + i), 8'(8'h90 + i)});
      for (int b = 0; b < 4; b++) begin
        drive(0, 0, 0, 0, 0, 1, 8'(8'h90 + 8'h10*b + i));
        chk($sformatf("rxfill w%0d b%0d rx_ready", i, b), 32'(rx_ready), 32'd1);
      end
    end
    for (int c = 0; c < 2; c++) begin
      drive(0, 0, 0, 0, 0, 1, 8'h99);
      chk($sformatf("rxfull c%0d rx_ready", c), 32'(rx_ready), 32'd0);
      chk($sformatf("rxfull c%0d status", c), status, 32'h0004_0000);
    end
    drive(0, 0, 0, 1, 0, 0, 8'h00);
    chk("rxfull pop rx_ready", 32'(rx_ready), 32'd0);
    chk("rxfull pop in_data", in_data, exp_wq.pop_front());
    drive(0, 0, 0, 0, 0, 1, 8'h99);
    chk("rxfull reopen rx_ready", 32'(rx_ready), 32'd1);
    chk("rxfull reopen status", status, 32'h0003_0000);
    for (int b = 1; b < 4; b++) drive(0, 0, 0, 0, 0, 1, 8'(8'hA0 + b));
    exp_wq.push_back(32'hA3A2A199);
    for (int j = 0; j < 4; j++) begin
      drive(0, 0, 0, 1, 0, 0, 8'h00);
      chk($sformatf("rxdrain %0d in_stall", j), 32'(in_stall), 32'd0);
      chk($sformatf("rxdrain %0d in_data", j), in_data, exp_wq.pop_front());
    end
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    chk("rxdrain end in_stall", 32'(in_stall), 32'd1);
    chk("rxdrain end status", status, 32'd0);

    // Reset mid-transfer: two TX beats sent, three RX beats assembled.
    drive(0, 1, 32'hCAFEF00D, 0, 1, 1, 8'hB0);
    drive(0, 0, 0, 0, 1, 1, 8'hB1);
    drive(0, 0, 0, 0, 1, 1, 8'hB2);
    chk("midrst beat0 tx_valid", 32'(tx_valid), 32'd1);
    chk("midrst beat0 tx_data", 32'(tx_data), 32'h0D);
    drive(0, 0, 0, 0, 1, 0, 8'h00);
    chk("midrst beat1 tx_data", 32'(tx_data), 32'hF0);
    drive(1, 0, 0, 0, 0, 0, 8'h00);
    chk("midrst beat2 tx_data", 32'(tx_data), 32'hFE);
    drive(0, 0, 0, 0, 0, 1, 8'h01);
    chk_reset_outputs("midrst after");
    for (int b = 2; b <= 4; b++) begin
      drive(0, 0, 0, 0, 0, 1, 8'(b));
      chk($sformatf("midrst rx b%0d tx_valid", b), 32'(tx_valid), 32'd0);
      chk($sformatf("midrst rx b%0d in_stall", b), 32'(in_stall), 32'd1);
    end
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    chk("midrst word in_stall", 32'(in_stall), 32'd0);
    chk("midrst word in_data", in_data, 32'h04030201);
    chk("midrst word status", status, 32'h0001_0000);
    drive(0, 0, 0, 1, 0, 0, 8'h00);
    drive(0, 0, 0, 0, 0, 0, 8'h00);
    chk("final in_stall", 32'(in_stall), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
